// File: rtl/cpu_mem_pkg.sv
// ============================================================================
//  Module      : cpu_mem_pkg
//  Description : Shared memory-subsystem types and default widths for the
//                unified RAM, its port arbiter and the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

  localparam int RAM_ADDR_W = 15;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_I    = 2'd1,
    RD_D    = 2'd2
  } rd_owner_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
//  Module      : ram_port_arbiter_if
//  Description : Fetch port, load/store port and RAM-side bus of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import cpu_mem_pkg::*;

interface ram_port_arbiter_if #(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  ram_en;
  logic                  ram_we;
  logic [DATA_W/8-1:0]   ram_be;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_en, ram_we, ram_be, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
//  Module      : arb_starve_ctr
//  Description : Saturating count of consecutive fetch denials; raises
//                force_fetch once the count reaches MAX_STARVE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_ctr #(
  parameter int MAX_STARVE = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic fetch_req,
  input  wire logic fetch_gnt,
  output logic      force_fetch
);

  localparam logic [3:0] C_MAX = 4'(MAX_STARVE);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!fetch_req || fetch_gnt) begin
      cnt <= '0;
    end else if (cnt != C_MAX) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_fetch = (cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Single-port RAM arbiter, D-priority with fetch starvation
//                guard. Optional stall counters under ARB_STALL_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import cpu_mem_pkg::*;

module ram_port_arbiter #(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int MAX_STARVE = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ram_port_arbiter_if.slave   bus
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [31:0]         i_stall_cnt,
  output logic [31:0]         d_stall_cnt
`endif
);

  localparam int BE_W = DATA_W / 8;

  logic              force_fetch;
  logic              grant_i;
  logic              grant_d;

  logic              mux_en;
  logic              mux_we;
  logic [BE_W-1:0]   mux_be;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  rd_owner_t         rd_own;
  rd_owner_t         rd_own_next;
  logic              i_rvalid_c;
  logic              d_rvalid_c;

  arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (bus.i_req),
    .fetch_gnt   (grant_i),
    .force_fetch (force_fetch)
  );

  // D wins any contest unless the fetch port has hit its starvation limit.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (bus.d_req && !(bus.i_req && force_fetch)) begin
      grant_d = 1'b1;
    end else if (bus.i_req) begin
      grant_i = 1'b1;
    end
  end

  always_comb begin
    mux_en    = 1'b0;
    mux_we    = 1'b0;
    mux_be    = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (grant_i) begin
      mux_en   = 1'b1;
      mux_be   = '1;
      mux_addr = bus.i_addr;
    end else if (grant_d) begin
      mux_en   = 1'b1;
      mux_we   = bus.d_we;
      mux_addr = bus.d_addr;
      if (bus.d_we) begin
        mux_be    = bus.d_be;
        mux_wdata = bus.d_wdata;
      end else begin
        mux_be    = '1;
      end
    end
  end

  assign bus.i_gnt     = grant_i;
  assign bus.d_gnt     = grant_d;
  assign bus.ram_en    = mux_en;
  assign bus.ram_we    = mux_we;
  assign bus.ram_be    = mux_be;
  assign bus.ram_addr  = mux_addr;
  assign bus.ram_wdata = mux_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_own <= RD_NONE;
    end else begin
      rd_own <= rd_own_next;
    end
  end

  // Stores never produce a read return, so they leave the owner at NONE.
  always_comb begin
    rd_own_next = RD_NONE;
    i_rvalid_c  = 1'b0;
    d_rvalid_c  = 1'b0;
    if (grant_i) begin
      rd_own_next = RD_I;
    end else if (grant_d && !bus.d_we) begin
      rd_own_next = RD_D;
    end
    i_rvalid_c = (rd_own == RD_I);
    d_rvalid_c = (rd_own == RD_D);
  end

  assign bus.i_rvalid = i_rvalid_c;
  assign bus.d_rvalid = d_rvalid_c;
  assign bus.i_rdata  = bus.ram_rdata;
  assign bus.d_rdata  = bus.ram_rdata;

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (bus.i_req && !grant_i) begin
        i_stall_cnt <= i_stall_cnt + 32'd1;
      end
      if (bus.d_req && !grant_d) begin
        d_stall_cnt <= d_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench: directed vector table, reset and
//                starvation sequences, then random traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

import cpu_mem_pkg::*;

module tb_ram_port_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 32;
  localparam int MAX_STARVE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STALL_CNT_EN
  logic [31:0] i_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  ram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_STALL_CNT_EN
    ,
    .i_stall_cnt (i_stall_cnt),
    .d_stall_cnt (d_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input logic [14:0] a);
    if (a == 15'h0010) return 32'h0000_0013;
    if (a == 15'h0020) return 32'hFFFF_FFFF;
    return 32'hC0DE_0000 ^ {17'd0, a} ^ {a, 17'd0};
  endfunction

  // Behavioural RAM: one-cycle read latency, byte-enabled writes.
  logic [31:0] ram_mem [int];
  logic [31:0] ram_q;
  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    if (bus.ram_en) begin
      w = ram_mem.exists(int'(bus.ram_addr)) ? ram_mem[int'(bus.ram_addr)]
                                             : init_word(bus.ram_addr);
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.ram_be[b]) w[8*b +: 8] = bus.ram_wdata[8*b +: 8];
        end
        ram_mem[int'(bus.ram_addr)] = w;
      end else begin
        ram_q <= w;
      end
    end
  end
  assign bus.ram_rdata = ram_q;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [14:0] ia, input logic dr,
                       input logic dwe, input logic [3:0] dbe,
                       input logic [14:0] da, input logic [31:0] dwd);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = dbe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ir;
    logic [14:0] ia;
    logic        dr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [14:0] da;
    logic [31:0] dwd;
    logic        eig;
    logic        edg;
    logic        eiv;
    logic        edv;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [15];

  // Reference model state for the random phase
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  initial begin
    int          starve;
    int          own;
    logic [31:0] pend;
    logic        pi, pd, dwe, eg_i, eg_d;
    logic [14:0] ia, da;
    logic [3:0]  dbe;
    logic [31:0] dwd, w;
    logic [31:0] exp_i_stall, exp_d_stall;

    //                ir  ia        dr  we  be    da        wdata          ig  dg  iv  dv  rdata
    tbl[0]  = '{1'b1, 15'h0010, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013};
    tbl[2]  = '{1'b0, 15'h0000, 1'b1, 1'b1, 4'hF, 15'h4011, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 15'h0000, 1'b1, 1'b0, 4'h0, 15'h4011, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 15'h0000, 1'b1, 1'b1, 4'h3, 15'h0020, 32'h12345678,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 15'h0000, 1'b1, 1'b0, 4'h0, 15'h0020, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF5678};
    tbl[8]  = '{1'b0, 15'h0000, 1'b1, 1'b1, 4'h0, 15'h0020, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 15'h0000, 1'b1, 1'b0, 4'h0, 15'h0020, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 15'h0000, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF5678};
    tbl[11] = '{1'b1, 15'h0010, 1'b1, 1'b0, 4'h0, 15'h4011, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 15'h0010, 1'b1, 1'b0, 4'h0, 15'h4011, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 15'h0010, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[14] = '{1'b0, 15'h0000, 1'b0, 1'b0, 4'h0, 15'h0000, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013};

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    chk("rst_gnts", {bus.i_gnt, bus.d_gnt}, 0);
    chk("rst_ram_idle", {bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata}, 0);
`ifdef ARB_STALL_CNT_EN
    chk("rst_i_stall", i_stall_cnt, 0);
    chk("rst_d_stall", d_stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].ir, tbl[r].ia, tbl[r].dr, tbl[r].dwe, tbl[r].dbe, tbl[r].da, tbl[r].dwd);
      #2;
      chk($sformatf("v%0d_i_gnt", r), bus.i_gnt, tbl[r].eig);
      chk($sformatf("v%0d_d_gnt", r), bus.d_gnt, tbl[r].edg);
      chk($sformatf("v%0d_i_rvalid", r), bus.i_rvalid, tbl[r].eiv);
      chk($sformatf("v%0d_d_rvalid", r), bus.d_rvalid, tbl[r].edv);
      if (tbl[r].eiv) chk($sformatf("v%0d_i_rdata", r), bus.i_rdata, tbl[r].erd);
      if (tbl[r].edv) chk($sformatf("v%0d_d_rdata", r), bus.d_rdata, tbl[r].erd);
      if (tbl[r].eig) begin
        chk($sformatf("v%0d_ram_i", r), {bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr},
            {1'b1, 1'b0, 4'hF, tbl[r].ia});
      end else if (tbl[r].edg) begin
        chk($sformatf("v%0d_ram_d", r), {bus.ram_en, bus.ram_we, bus.ram_addr},
            {1'b1, tbl[r].dwe, tbl[r].da});
        if (tbl[r].dwe)
          chk($sformatf("v%0d_ram_wr", r), {bus.ram_be, bus.ram_wdata}, {tbl[r].dbe, tbl[r].dwd});
      end else begin
        chk($sformatf("v%0d_ram_idle", r),
            {bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata}, 0);
      end
      @(negedge clk);
    end

    // Reset asserted before the edge that would register a fetch grant
    do_reset();
    drive(1, 15'h0010, 0, 0, 0, 0, 0);
    #2;
    chk("rstA_i_gnt", bus.i_gnt, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk("rstA_rvalid_in_rst", bus.i_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("rstA_rvalid_rel0", bus.i_rvalid, 0);
    @(negedge clk);
    #2 chk("rstA_rvalid_rel1", bus.i_rvalid, 0);
    @(negedge clk);

    // Reset asserted while the read return is on the bus
    drive(1, 15'h0010, 0, 0, 0, 0, 0);
    #2 chk("rstB_i_gnt", bus.i_gnt, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk("rstB_rvalid_pre", bus.i_rvalid, 1);
    rst_n = 1'b0;
    #1 chk("rstB_rvalid_drop", bus.i_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("rstB_rvalid_rel0", bus.i_rvalid, 0);
    @(negedge clk);
    #2 chk("rstB_rvalid_rel1", bus.i_rvalid, 0);
    @(negedge clk);

    // Both ports requesting continuously from a fresh starvation count
    for (int k = 0; k < 10; k++) begin
      drive(1, 15'h0100, 1, 0, 0, 15'h0101, 0);
      #2;
      chk($sformatf("starve%0d_i_gnt", k), bus.i_gnt, (k % 5) == 4);
      chk($sformatf("starve%0d_d_gnt", k), bus.d_gnt, (k % 5) != 4);
      chk($sformatf("starve%0d_onehot", k), bus.i_gnt & bus.d_gnt, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
`ifdef ARB_STALL_CNT_EN
    chk("starve_i_stall", i_stall_cnt, 8);
    chk("starve_d_stall", d_stall_cnt, 2);
`endif
    @(negedge clk);

    // Random traffic against the reference model
    do_reset();
    foreach (ram_mem[k]) ref_mem[k] = ram_mem[k];
    starve = 0; own = 0; pend = '0; pi = 0; pd = 0;
    ia = '0; da = '0; dwe = 0; dbe = '0; dwd = '0;
    exp_i_stall = '0; exp_d_stall = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        pi = 1'b1;
        ia = 15'h0100 + 15'($urandom_range(0, 15));
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd  = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom_range(0, 15));
        da  = 15'h0100 + 15'($urandom_range(0, 15));
        dwd = $urandom;
      end
      drive(pi, ia, pd, dwe, dbe, da, dwd);
      #2;
      eg_d = pd && !(pi && starve == MAX_STARVE);
      eg_i = pi && !eg_d;
      chk("rnd_i_gnt", bus.i_gnt, eg_i);
      chk("rnd_d_gnt", bus.d_gnt, eg_d);
      chk("rnd_i_rvalid", bus.i_rvalid, own == 1);
      chk("rnd_d_rvalid", bus.d_rvalid, own == 2);
      if (own == 1) chk("rnd_i_rdata", bus.i_rdata, pend);
      if (own == 2) chk("rnd_d_rdata", bus.d_rdata, pend);
      if (eg_i) chk("rnd_ram_i", {bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr}, {1'b1, 1'b0, 4'hF, ia});
      if (eg_d) chk("rnd_ram_d", {bus.ram_en, bus.ram_we, bus.ram_addr}, {1'b1, dwe, da});
      if (eg_d && dwe) chk("rnd_ram_wr", {bus.ram_be, bus.ram_wdata}, {dbe, dwd});
      if (!eg_i && !eg_d) chk("rnd_ram_idle", {bus.ram_en, bus.ram_addr}, 0);

      own = 0;
      if (eg_i) begin
        own  = 1;
        pend = ref_rd(ia);
      end else if (eg_d && !dwe) begin
        own  = 2;
        pend = ref_rd(da);
      end else if (eg_d) begin
        w = ref_rd(da);
        for (int b = 0; b < 4; b++) if (dbe[b]) w[8*b +: 8] = dwd[8*b +: 8];
        ref_mem[int'(da)] = w;
      end
      starve = (pi && !eg_i) ? ((starve < MAX_STARVE) ? starve + 1 : MAX_STARVE) : 0;
      if (pi && !eg_i) exp_i_stall = exp_i_stall + 32'd1;
      if (pd && !eg_d) exp_d_stall = exp_d_stall + 32'd1;
      if (eg_i) pi = 1'b0;
      if (eg_d) pd = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        pi = 1'b0;
        pd = 1'b0;
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
`ifdef ARB_STALL_CNT_EN
    chk("rnd_i_stall", i_stall_cnt, exp_i_stall);
    chk("rnd_d_stall", d_stall_cnt, exp_d_stall);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port unified RAM between the CPU instruction-fetch port (I) and the load/store data port (D).
- Sits in CPUTop between the fetch/memory stages and the RAM instance.
- Grants at most one access per cycle. Read data returns one cycle after the grant.
- Fixed priority favours D. A starvation guard forces an I grant after MAX_STARVE consecutive denials.

Parameters:
- ADDR_W, 15, RAM word-address width (32K words).
- DATA_W, 32, data width.
- MAX_STARVE, 4, consecutive I denials before I is forced priority; range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request (read only).
- i_addr  in  ADDR_W  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid (cycle after i_gnt).
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid (cycle after a load grant; never for stores).
- d_rdata  out  DATA_W  load data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_be  out  DATA_W/8  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe.

Behaviour:
- Requesters hold req/addr/data stable until they see gnt high in the same cycle. The arbiter never grants a port whose req is low.
- gnt, ram_en, ram_we, ram_be, ram_addr and ram_wdata are combinational from req and state. A grant drives the RAM in the same cycle.
- Priority when both ports request:
  - D wins unless starve_cnt == MAX_STARVE.
  - At starve_cnt == MAX_STARVE, I wins.
- starve_cnt (4 bits) update:
  - Increments when i_req && !i_gnt.
  - Clears when i_gnt or !i_req.
  - Saturates at MAX_STARVE.
- At most one of i_gnt / d_gnt is high in any cycle.
- Idle cycle (no grant): ram_en=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0.
- Grant encodings:
  - I grant: ram_we=0, ram_be=all ones.
  - D store: ram_we=1, ram_be=d_be. d_be=0 is still a granted no-op write.
- Read-return FSM, registered owner rd_own ∈ {NONE, I, D}:
  - Next rd_own = I on an I grant, D on a D load grant, NONE otherwise (including stores).
  - i_rvalid = (rd_own==I); d_rvalid = (rd_own==D).
  - i_rdata and d_rdata both pass ram_rdata through. Only the rvalid qualifies them.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle, load-to-data latency is 1.
- A store followed by a load to the same address on the next cycle returns the new data. The RAM is write-first on sequential cycles; no forwarding is done here.
- Reset (async assert, sync-to-clk release):
  - rd_own=NONE, starve_cnt=0, i_rvalid=0, d_rvalid=0.
  - Reset asserted mid-access drops the outstanding read; no rvalid after release.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- Defined:
  - Adds outputs i_stall_cnt and d_stall_cnt (32 bits each, reset 0).
  - A counter increments each cycle its port has req && !gnt. It wraps modulo 2^32.
  - Intended for CPI analysis on the bench.
- Undefined: these ports and counters do not exist. Arbitration is identical.

Decomposition:
- Shared package cpu_mem_pkg:
  - rd_owner_t enum (NONE/I/D).
  - Default RAM_ADDR_W and DATA_W constants, shared with the RAM and the LSU.
- One natural sub-module: arb_starve_ctr, the saturating starvation counter with its priority-override output.
- The mux and return FSM stay in the top.

Test Plan:
- Only i_req, i_addr=0x0010, RAM word=0x00000013 → i_gnt=1 same cycle, i_rvalid=1 next cycle with i_rdata=0x00000013, d_rvalid=0.
- d_req store d_addr=0x4011, d_wdata=0xDEADBEEF, d_be=0xF, then a load at the same address next cycle → d_gnt both cycles, no rvalid after the store, d_rvalid with 0xDEADBEEF after the load.
- i_req and d_req held continuously with MAX_STARVE=4 → grant pattern D,D,D,D,I repeating; never two grants in one cycle.
- d_be=0x3 store of 0x12345678 over 0xFFFFFFFF, then a load → 0xFFFF5678.
- rst_n pulled low the cycle after an I grant → i_rvalid stays 0 through release; starve_cnt reads 0.
- With ARB_STALL_CNT_EN, 10 cycles of both ports requesting (MAX_STARVE=4) → i_stall_cnt=8, d_stall_cnt=2.
